mc_controller_ws: RTL and testbench
===================================

MC_CONTROLLER_WS -- requirements
Module: mc_controller_ws

Interface
- REQ-001 SHALL have parameter MAX_WAIT, default 15: memory-wait cycles tolerated per access before fault (1..255).
- REQ-002 SHALL have ports:
  - clk  in  1  rising-edge clock.
  - reset  in  1  synchronous, active-high.
  - opcode  in  6  instruction[31:26].
  - funct  in  6  instruction[5:0].
  - zero  in  1  ALU zero flag.
  - mem_ready  in  1  memory access completes this cycle.
  - memread  out  1  memory read request.
  - memwrite  out  1  memory write request.
  - iord  out  1  0 = PC address, 1 = ALUOut address.
  - irwrite  out  1  IR load enable.
  - regdst  out  1  1 = rd, 0 = rt.
  - memtoreg  out  1  1 = data reg, 0 = ALUOut.
  - regwrite  out  1  register file write enable.
  - alusrca  out  1  0 = PC, 1 = A.
  - alusrcb  out  2  00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
  - alucontrol  out  3  ALU operation.
  - pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
  - pcen  out  1  PC write enable.
  - err  out  1  sticky fault flag.

Function
- REQ-003 SHALL be a Moore FSM with registered state; outputs are combinational from state, plus mem_ready, opcode, funct and zero as stated below.
- REQ-004 States and transitions:
  - FETCH: to DECODE on mem_ready; otherwise stay.
  - DECODE: lw/sw (100011/101011) to MEMADR; R-type (000000) to EXEC; beq (000100) to BRANCH; extension opcodes per REQ-016; any other opcode to ERROR.
  - MEMADR: lw to MEMRD, sw to MEMWR.
  - MEMRD: to MEMWB on mem_ready.
  - MEMWB: to FETCH.
  - MEMWR: to FETCH on mem_ready.
  - EXEC: to ALUWB.
  - ALUWB: to FETCH.
  - BRANCH: to FETCH.
  - ERROR: absorbing until reset.
- REQ-005 FETCH outputs: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=mem_ready, pcen=mem_ready.
- REQ-006 DECODE outputs: alusrca=0, alusrcb=11, alucontrol=010.
- REQ-007 MEMADR outputs: alusrca=1, alusrcb=10, alucontrol=010.
- REQ-008 MEMRD outputs: memread=1, iord=1.
- REQ-008a MEMWR outputs: memwrite=1, iord=1.
- REQ-008b MEMWB outputs: regdst=0, memtoreg=1, regwrite=1.
- REQ-009 EXEC outputs: alusrca=1, alusrcb=00, alucontrol decoded from funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; other funct values go to ERROR at the next edge.
- REQ-010 ALUWB outputs: regdst=1, memtoreg=0, regwrite=1.
- REQ-010a BRANCH outputs: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=zero.
- REQ-011 Every output not listed for a state SHALL be 0 in that state.
- REQ-012 Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle the FSM is in one of those states with mem_ready=0.
  - Reaching MAX_WAIT with mem_ready still 0 transitions to ERROR.
  - mem_ready=1 on the same cycle the count reaches MAX_WAIT completes the access normally; completion takes priority.
- REQ-013 ERROR: all outputs 0 except err=1; memread, memwrite, regwrite and pcen SHALL never assert there.
- REQ-014 An instruction with no waits SHALL take: lw 5 cycles, sw 4, R-type 4, beq 3.

Reset
- REQ-015 reset=1 at a rising edge SHALL, from any state including mid-access or ERROR:
  - set state to FETCH,
  - clear the wait counter,
  - clear err.
  - While reset is held, all outputs SHALL be 0 except the FETCH combinational values.

Configuration
- REQ-016 Macro MC_EXT_ISA_EN defined SHALL add the following:
  - addi (001000): ADDIEX (alusrca=1, alusrcb=10, alucontrol=010), then ADDIWB (regdst=0, memtoreg=0, regwrite=1), then FETCH.
  - j (000010): JUMP (pcsrc=10, pcen=1), then FETCH.
  - bne (000101): BRANCHNE, identical to BRANCH except pcen=~zero.
- REQ-017 Without MC_EXT_ISA_EN, opcodes 001000, 000010 and 000101 SHALL go to ERROR from DECODE.

Verification
- REQ-018 The bench SHALL cover these directed scenarios:
  - Reset, then lw with mem_ready always 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5 only.
  - sw with mem_ready low 3 cycles in MEMWR → memwrite high 4 cycles, iord=1; then FETCH.
  - beq with zero=1 → pcen=1, pcsrc=01 in BRANCH; beq with zero=0 → pcen=0.
  - MAX_WAIT=4, mem_ready held 0 in FETCH → ERROR after 4 cycles, err=1, irwrite never 1; then reset → FETCH, err=0.
  - Opcode 001000 in DECODE: with MC_EXT_ISA_EN → ADDIEX, ADDIWB, regdst=0; without it → ERROR.
  - R-type funct 101010 → alucontrol=111 in EXEC; funct 000000 → ERROR at the next edge.

Source files
------------

// File: rtl/mc_controller_ws.sv
// Multicycle MIPS-style control FSM with a bounded memory-wait watchdog.
// Optional macro MC_EXT_ISA_EN adds addi, j and bne sequencing.
module mc_controller_ws #(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       err
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
`ifdef MC_EXT_ISA_EN
        ADDIEX,
        ADDIWB,
        JUMP,
        BRANCHNE,
`endif
        ERROR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_EXT_ISA_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] wcnt;
    logic       waiting;
    logic       timeout;
    logic       fn_ok;
    logic [2:0] fn_alu;

    assign timeout = (wcnt == WAIT_LAST);

    // R-type funct to ALU operation; unknown functs are flagged illegal
    always_comb begin
        fn_ok  = 1'b1;
        fn_alu = 3'b000;
        case (funct)
            6'b100000: fn_alu = 3'b010;
            6'b100010: fn_alu = 3'b110;
            6'b100100: fn_alu = 3'b000;
            6'b100101: fn_alu = 3'b001;
            6'b101010: fn_alu = 3'b111;
            default:   fn_ok  = 1'b0;
        endcase
    end

    // Next-state selection; memory completion wins over the watchdog
    always_comb begin
        state_n = state;
        waiting = 1'b0;
        case (state)
            FETCH: begin
                waiting = 1'b1;
                if (mem_ready)    state_n = DECODE;
                else if (timeout) state_n = ERROR;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = EXEC;
                    OP_BEQ:       state_n = BRANCH;
`ifdef MC_EXT_ISA_EN
                    OP_ADDI:      state_n = ADDIEX;
                    OP_J:         state_n = JUMP;
                    OP_BNE:       state_n = BRANCHNE;
`endif
                    default:      state_n = ERROR;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      state_n = MEMRD;
                else if (opcode == OP_SW) state_n = MEMWR;
                else                      state_n = ERROR;
            end
            MEMRD: begin
                waiting = 1'b1;
                if (mem_ready)    state_n = MEMWB;
                else if (timeout) state_n = ERROR;
            end
            MEMWB:  state_n = FETCH;
            MEMWR: begin
                waiting = 1'b1;
                if (mem_ready)    state_n = FETCH;
                else if (timeout) state_n = ERROR;
            end
            EXEC:   state_n = fn_ok ? ALUWB : ERROR;
            ALUWB:  state_n = FETCH;
            BRANCH: state_n = FETCH;
`ifdef MC_EXT_ISA_EN
            ADDIEX:   state_n = ADDIWB;
            ADDIWB:   state_n = FETCH;
            JUMP:     state_n = FETCH;
            BRANCHNE: state_n = FETCH;
`endif
            ERROR:  state_n = ERROR;
            default: state_n = ERROR;
        endcase
    end

    // State register and wait counter; counter restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            wcnt  <= 8'd0;
        end else begin
            state <= state_n;
            if (waiting && !mem_ready && state_n == state)
                wcnt <= wcnt + 8'd1;
            else
                wcnt <= 8'd0;
        end
    end

    // Moore outputs per state, gated by mem_ready / zero where needed
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        err        = 1'b0;
        case (state)
            FETCH: begin
                memread    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irwrite    = mem_ready;
                pcen       = mem_ready;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            EXEC: begin
                alusrca    = 1'b1;
                alucontrol = fn_alu;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
`ifdef MC_EXT_ISA_EN
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            BRANCHNE: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = ~zero;
            end
`endif
            ERROR: err = 1'b1;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Directed bench for mc_controller_ws built with MAX_WAIT=4.
// Output vector: memread,memwrite,iord,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,alucontrol,pcsrc,pcen,err.
module tb_mc_controller_ws;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       memread, memwrite, iord, irwrite;
    logic       regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       pcen, err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [16:0] E_FR    = 17'b1_0_0_1_0_0_0_0_01_010_00_1_0;
    localparam logic [16:0] E_FW    = 17'b1_0_0_0_0_0_0_0_01_010_00_0_0;
    localparam logic [16:0] E_DEC   = 17'b0_0_0_0_0_0_0_0_11_010_00_0_0;
    localparam logic [16:0] E_ADR   = 17'b0_0_0_0_0_0_0_1_10_010_00_0_0;
    localparam logic [16:0] E_MRD   = 17'b1_0_1_0_0_0_0_0_00_000_00_0_0;
    localparam logic [16:0] E_MWR   = 17'b0_1_1_0_0_0_0_0_00_000_00_0_0;
    localparam logic [16:0] E_MWB   = 17'b0_0_0_0_0_1_1_0_00_000_00_0_0;
    localparam logic [16:0] E_ALUWB = 17'b0_0_0_0_1_0_1_0_00_000_00_0_0;
    localparam logic [16:0] E_BRT   = 17'b0_0_0_0_0_0_0_1_00_110_01_1_0;
    localparam logic [16:0] E_BRN   = 17'b0_0_0_0_0_0_0_1_00_110_01_0_0;
    localparam logic [16:0] E_ERR   = 17'b0_0_0_0_0_0_0_0_00_000_00_0_1;
    localparam logic [16:0] E_ADDWB = 17'b0_0_0_0_0_0_1_0_00_000_00_0_0;

    mc_controller_ws #(.MAX_WAIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .opcode(opcode),
        .funct(funct),
        .zero(zero),
        .mem_ready(mem_ready),
        .memread(memread),
        .memwrite(memwrite),
        .iord(iord),
        .irwrite(irwrite),
        .regdst(regdst),
        .memtoreg(memtoreg),
        .regwrite(regwrite),
        .alusrca(alusrca),
        .alusrcb(alusrcb),
        .alucontrol(alucontrol),
        .pcsrc(pcsrc),
        .pcen(pcen),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs();
        return {memread, memwrite, iord, irwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, alucontrol, pcsrc, pcen, err};
    endfunction

    function automatic logic [16:0] e_exec(input logic [2:0] alu);
        return {8'b0000_0001, 2'b00, alu, 2'b00, 1'b0, 1'b0};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr);
        @(negedge clk);
        reset     = 1'b0;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = mr;
        #1;
    endtask

    task automatic test_reset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (obs() !== E_FW) begin
            miscompares++;
            $display("FAIL reset_%s_nr got %b want %b", tag, obs(), E_FW);
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (obs() !== E_FR) begin
            miscompares++;
            $display("FAIL reset_%s_rdy got %b want %b", tag, obs(), E_FR);
        end
    endtask

    task automatic test_lw();
        logic [16:0] ex [5] = '{E_FR, E_DEC, E_ADR, E_MRD, E_MWB};
        for (int i = 0; i < 5; i++) begin
            drive(6'b100011, 6'b0, 1'b0, 1'b1);
            vectors++;
            if (obs() !== ex[i]) begin
                miscompares++;
                $display("FAIL lw_c%0d got %b want %b", i + 1, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_sw_wait();
        logic [16:0] ex [7] = '{E_FR, E_DEC, E_ADR, E_MWR, E_MWR, E_MWR, E_MWR};
        logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(6'b101011, 6'b0, 1'b0, mr[i]);
            vectors++;
            if (obs() !== ex[i]) begin
                miscompares++;
                $display("FAIL sw_c%0d got %b want %b", i + 1, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_lw_wait_limit();
        logic [16:0] ex [8] = '{E_FR, E_DEC, E_ADR, E_MRD, E_MRD, E_MRD, E_MRD, E_MWB};
        logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive(6'b100011, 6'b0, 1'b0, mr[i]);
            vectors++;
            if (obs() !== ex[i]) begin
                miscompares++;
                $display("FAIL lwlim_c%0d got %b want %b", i + 1, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_beq();
        logic [16:0] ex [6] = '{E_FR, E_DEC, E_BRT, E_FR, E_DEC, E_BRN};
        logic        z  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(6'b000100, 6'b0, z[i], 1'b1);
            vectors++;
            if (obs() !== ex[i]) begin
                miscompares++;
                $display("FAIL beq_c%0d got %b want %b", i + 1, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] alu [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        logic [16:0] ex [4];
        for (int k = 0; k < 5; k++) begin
            ex = '{E_FR, E_DEC, e_exec(alu[k]), E_ALUWB};
            for (int i = 0; i < 4; i++) begin
                drive(6'b000000, fns[k], 1'b0, 1'b1);
                vectors++;
                if (obs() !== ex[i]) begin
                    miscompares++;
                    $display("FAIL rtype_f%b_c%0d got %b want %b",
                             fns[k], i + 1, obs(), ex[i]);
                end
            end
        end
    endtask

    task automatic test_bad_funct();
        logic [16:0] ex [5] = '{E_FR, E_DEC, e_exec(3'b000), E_ERR, E_ERR};
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, 6'b000000, 1'b1, 1'b1);
            vectors++;
            if (obs() !== ex[i]) begin
                miscompares++;
                $display("FAIL badfn_c%0d got %b want %b", i + 1, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_fetch_timeout();
        logic [16:0] ex [7] = '{E_FW, E_FW, E_FW, E_FW, E_ERR, E_ERR, E_ERR};
        logic        mr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            drive(6'b100011, 6'b0, 1'b1, mr[i]);
            vectors++;
            if (obs() !== ex[i]) begin
                miscompares++;
                $display("FAIL timeout_c%0d got %b want %b", i + 1, obs(), ex[i]);
            end
        end
    endtask

    task automatic test_addi();
`ifdef MC_EXT_ISA_EN
        logic [16:0] ex [4] = '{E_FR, E_DEC, E_ADR, E_ADDWB};
`else
        logic [16:0] ex [4] = '{E_FR, E_DEC, E_ERR, E_ERR};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(6'b001000, 6'b0, 1'b0, 1'b1);
            vectors++;
            if (obs() !== ex[i]) begin
                miscompares++;
                $display("FAIL addi_c%0d got %b want %b", i + 1, obs(), ex[i]);
            end
        end
    endtask

    initial begin
        test_reset("init");
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype();
        test_lw_wait_limit();
        test_bad_funct();
        test_reset("after_badfn");
        test_fetch_timeout();
        test_reset("after_timeout");
        test_addi();
        test_reset("after_addi");
        test_lw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
